// File: rtl/cnn_pkg.sv
// Shared types and constants for the classifier result path.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // All segments off on the active-low displays.
    localparam logic [6:0] HEX_BLANK = 7'h7F;

    // Logits are Q16.16 fixed point.
    localparam int Q_FRAC_BITS = 16;

    // Word index width: covers N_NEURONS up to 10 plus the cycle-count word.
    localparam int IDX_W = 4;

    // Tag travelling alongside an outstanding RAM read.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex digit to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module seven_seg_decoder
    import cnn_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    // Glyph lookup for digits 0-F.
    always_comb begin
        segments = HEX_BLANK;
        case (digit)
            4'h0: segments = 7'h40;
            4'h1: segments = 7'h79;
            4'h2: segments = 7'h24;
            4'h3: segments = 7'h30;
            4'h4: segments = 7'h19;
            4'h5: segments = 7'h12;
            4'h6: segments = 7'h02;
            4'h7: segments = 7'h78;
            4'h8: segments = 7'h00;
            4'h9: segments = 7'h10;
            4'hA: segments = 7'h08;
            4'hB: segments = 7'h03;
            4'hC: segments = 7'h46;
            4'hD: segments = 7'h21;
            4'hE: segments = 7'h06;
            4'hF: segments = 7'h0E;
            default: segments = HEX_BLANK;
        endcase
    end

endmodule

// File: rtl/logit_result_reader.sv
// Reads the classifier logits from the result RAM, finds the argmax and
// drives LEDs plus six 7-segment displays.
// Build option: LOGIT_READER_CYCLES_EN also reads the total-cycle word that
// follows the logits and allows it to be shown on hex1..hex5.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for start_i after reset
// ST_READ  | presenting one RAM address per cycle
// ST_DRAIN | waiting for the last outstanding read to return
// ST_DONE  | results held, start_i re-arms a new read
module logit_result_reader
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 16,
    parameter int N_NEURONS        = 10,
    parameter int LOGIT_BASE_ADDR  = 1,
    parameter int RAM_READ_LATENCY = 2
) (
    input  logic                  system_clock,
    input  logic                  global_reset,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] ram_q_i,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress_o,
    input  logic                  display_sel_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [3:0]            class_o,
    output logic [DATA_WIDTH-1:0] max_logit_o,
    output logic [DATA_WIDTH-1:0] total_cycles_o,
    output logic [9:0]            leds_o,
    output logic [6:0]            hex0_o,
    output logic [6:0]            hex1_o,
    output logic [6:0]            hex2_o,
    output logic [6:0]            hex3_o,
    output logic [6:0]            hex4_o,
    output logic [6:0]            hex5_o
);

`ifdef LOGIT_READER_CYCLES_EN
    localparam bit CYCLES_EN = 1'b1;
`else
    localparam bit CYCLES_EN = 1'b0;
`endif
    localparam int N_WORDS = CYCLES_EN ? N_NEURONS + 1 : N_NEURONS;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(LOGIT_BASE_ADDR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    state_t           state;
    logic [IDX_W-1:0] issue_idx;
    logic             accept;
    logic             last_seen;
    rd_tag_t          tag_pipe [RAM_READ_LATENCY];
    rd_tag_t          tag_out;
    logic [6:0]       seg [6];

    assign accept  = start_i && ((state == ST_IDLE) || (state == ST_DONE));
    assign tag_out = tag_pipe[RAM_READ_LATENCY-1];

    // Sequencing FSM: address generation, busy/done and LED outputs.
    always_ff @(posedge system_clock or posedge global_reset) begin
        if (global_reset) begin
            state           <= ST_IDLE;
            issue_idx       <= '0;
            ram_rdaddress_o <= BASE;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            leds_o          <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state           <= ST_READ;
                        issue_idx       <= '0;
                        ram_rdaddress_o <= BASE;
                        done_o          <= 1'b0;
                        leds_o          <= '0;
                    end
                end
                ST_READ: begin
                    busy_o <= 1'b1;
                    if (issue_idx == LAST_IDX) begin
                        state <= ST_DRAIN;
                    end else begin
                        issue_idx       <= issue_idx + IDX_W'(1);
                        ram_rdaddress_o <= ram_rdaddress_o + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    // last_seen is set on the edge that consumed the final word,
                    // so class_o is already final here.
                    if (last_seen) begin
                        state  <= ST_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        leds_o <= 10'(1) << class_o;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Return tracking and argmax over the words coming back from the RAM.
    always_ff @(posedge system_clock or posedge global_reset) begin
        if (global_reset) begin
            for (int i = 0; i < RAM_READ_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
            max_logit_o    <= '0;
            class_o        <= '0;
            total_cycles_o <= '0;
            last_seen      <= 1'b0;
        end else begin
            tag_pipe[0].valid <= (state == ST_READ);
            tag_pipe[0].idx   <= issue_idx;
            for (int i = 1; i < RAM_READ_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (accept) begin
                last_seen <= 1'b0;
            end else if (tag_out.valid) begin
                if (tag_out.idx == '0) begin
                    max_logit_o <= ram_q_i;
                    class_o     <= '0;
                end else if ((tag_out.idx < IDX_W'(N_NEURONS)) &&
                             ($signed(ram_q_i) > $signed(max_logit_o))) begin
                    // Strictly greater: on a tie the lower index wins.
                    max_logit_o <= ram_q_i;
                    class_o     <= tag_out.idx;
                end
`ifdef LOGIT_READER_CYCLES_EN
                if (tag_out.idx == IDX_W'(N_NEURONS)) begin
                    total_cycles_o <= ram_q_i;
                end
`endif
                if (tag_out.idx == LAST_IDX) begin
                    last_seen <= 1'b1;
                end
            end
        end
    end

    seven_seg_decoder u_dec0 (.digit(class_o),              .segments(seg[0]));
    seven_seg_decoder u_dec1 (.digit(total_cycles_o[3:0]),   .segments(seg[1]));
    seven_seg_decoder u_dec2 (.digit(total_cycles_o[7:4]),   .segments(seg[2]));
    seven_seg_decoder u_dec3 (.digit(total_cycles_o[11:8]),  .segments(seg[3]));
    seven_seg_decoder u_dec4 (.digit(total_cycles_o[15:12]), .segments(seg[4]));
    seven_seg_decoder u_dec5 (.digit(total_cycles_o[19:16]), .segments(seg[5]));

    // Display mux: blank unless results are valid; display_sel_i acts live in DONE.
    always_comb begin
        hex0_o = done_o ? seg[0] : HEX_BLANK;
        hex1_o = HEX_BLANK;
        hex2_o = HEX_BLANK;
        hex3_o = HEX_BLANK;
        hex4_o = HEX_BLANK;
        hex5_o = HEX_BLANK;
        if (CYCLES_EN && done_o && display_sel_i) begin
            hex1_o = seg[1];
            hex2_o = seg[2];
            hex3_o = seg[3];
            hex4_o = seg[4];
            hex5_o = seg[5];
        end
    end

endmodule

// File: tb/tb_logit_result_reader.sv
// Self-checking bench for logit_result_reader with a latency-accurate RAM model.
module tb_logit_result_reader;

    localparam int N    = 10;
    localparam int L    = 2;
    localparam int BASE = 1;
`ifdef LOGIT_READER_CYCLES_EN
    localparam bit CYC = 1'b1;
`else
    localparam bit CYC = 1'b0;
`endif
    localparam int NW = CYC ? N + 1 : N;
    localparam logic [6:0] BLANK = 7'h7F;

    logic        clk;
    logic        global_reset;
    logic        start_i;
    logic [31:0] ram_q;
    logic [15:0] ram_addr;
    logic        display_sel;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  class_o;
    logic [31:0] max_logit_o;
    logic [31:0] total_cycles_o;
    logic [9:0]  leds_o;
    logic [6:0]  hex [6];

    logic [31:0] mem [64];
    logic [15:0] a_pipe [L];

    int checks = 0;
    int errors = 0;

    logit_result_reader dut (
        .system_clock    (clk),
        .global_reset    (global_reset),
        .start_i         (start_i),
        .ram_q_i         (ram_q),
        .ram_rdaddress_o (ram_addr),
        .display_sel_i   (display_sel),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .class_o         (class_o),
        .max_logit_o     (max_logit_o),
        .total_cycles_o  (total_cycles_o),
        .leds_o          (leds_o),
        .hex0_o          (hex[0]),
        .hex1_o          (hex[1]),
        .hex2_o          (hex[2]),
        .hex3_o          (hex[3]),
        .hex4_o          (hex[4]),
        .hex5_o          (hex[5])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM: address captured on each edge, data appears L edges later.
    always @(posedge clk) begin
        a_pipe[0] <= ram_addr;
        for (int i = 1; i < L; i++) a_pipe[i] <= a_pipe[i-1];
    end
    assign ram_q = mem[a_pipe[L-1][5:0]];

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic int model_class();
        int best = 0;
        for (int k = 1; k < N; k++)
            if ($signed(mem[BASE+k]) > $signed(mem[BASE+best])) best = k;
        return best;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ":busy"},  busy_o, 0);
        chk({tag, ":done"},  done_o, 0);
        chk({tag, ":class"}, class_o, 0);
        chk({tag, ":max"},   max_logit_o, 0);
        chk({tag, ":total"}, total_cycles_o, 0);
        chk({tag, ":leds"},  leds_o, 0);
        chk({tag, ":addr"},  ram_addr, BASE);
        for (int i = 0; i < 6; i++) chk($sformatf("%s:hex%0d", tag, i), hex[i], BLANK);
    endtask

    task automatic check_hex_cycles(input string tag, input logic [31:0] tot);
        for (int i = 1; i < 6; i++)
            chk($sformatf("%s:hex%0d", tag, i), hex[i],
                (CYC && display_sel) ? glyph(4'((tot >> (4*(i-1))) & 32'hF)) : BLANK);
    endtask

    // Pulse start, optionally pulse start again at edge 'extra', wait for done.
    task automatic run_and_check(input string tag, input int extra);
        int          ecls;
        logic [31:0] emax, etot;
        int          lat;
        bit          viol;
        ecls = model_class();
        emax = mem[BASE+ecls];
        etot = CYC ? mem[BASE+N] : 32'h0;
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        chk({tag, ":done_clr"}, done_o, 0);
        lat = 0; viol = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            if (e == extra) start_i = 1'b1;
            @(posedge clk); #1; start_i = 1'b0;
            if (done_o) begin
                lat = e;
                break;
            end
            if (busy_o !== 1'b1 || leds_o !== 10'd0 || hex[0] !== BLANK || hex[5] !== BLANK)
                viol = 1'b1;
        end
        chk({tag, ":latency"}, lat, NW + L + 1);
        chk({tag, ":busy_window"}, viol, 0);
        chk({tag, ":busy_off"}, busy_o, 0);
        chk({tag, ":class"}, class_o, ecls);
        chk({tag, ":max"}, max_logit_o, emax);
        chk({tag, ":total"}, total_cycles_o, etot);
        chk({tag, ":leds"}, leds_o, 32'h1 << ecls);
        chk({tag, ":hex0"}, hex[0], glyph(4'(ecls)));
        check_hex_cycles(tag, etot);
    endtask

    logic [31:0] t1 [10] = '{32'h654, 32'h2BD9, 32'hFFFFFAA6, 32'hFFFFEFBA, 32'hFFFFEDCB,
                             32'hFFFFF75A, 32'hFFFFF8F2, 32'h8C6, 32'hF7, 32'h1DA};

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        global_reset = 1'b1;
        start_i      = 1'b0;
        display_sel  = 1'b0;
        repeat (2) @(posedge clk);
        // start coincident with reset must be ignored
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        check_reset("reset");
        @(negedge clk); global_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("start_in_reset:busy", busy_o, 0);
        chk("start_in_reset:done", done_o, 0);

        // winner at index 1, with cycle word
        for (int k = 0; k < N; k++) mem[BASE+k] = t1[k];
        mem[BASE+N] = 32'h00012345;
        display_sel = 1'b1;
        run_and_check("winner1", -1);
        chk("winner1:class_const", class_o, 1);
        chk("winner1:leds_const", leds_o, 10'b0000000010);
        @(negedge clk); display_sel = 1'b0;
        #1;
        check_hex_cycles("sel0", 32'h00012345);

        // all negative, largest at index 9
        for (int k = 0; k < N - 1; k++) mem[BASE+k] = 32'hFFFFFFF0 - $urandom_range(1, 5000);
        mem[BASE+9] = 32'hFFFFFFF0;
        run_and_check("allneg", -1);
        chk("allneg:hex0_9", hex[0], 7'h10);

        // tie between 3 and 6
        for (int k = 0; k < N; k++) mem[BASE+k] = 32'h0;
        mem[BASE+3] = 32'h10000;
        mem[BASE+6] = 32'h10000;
        run_and_check("tie", -1);
        chk("tie:class_const", class_o, 3);

        // randomized runs, alternating wide values and tie-prone small values
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k <= N; k++)
                mem[BASE+k] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
            display_sel = 1'($urandom_range(0, 1));
            run_and_check($sformatf("rand%0d", r), -1);
        end

        // reset mid-read
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1; start_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); global_reset = 1'b1;
        #1;
        check_reset("midreset");
        @(posedge clk);
        @(negedge clk); global_reset = 1'b0;
        for (int k = 0; k <= N; k++) mem[BASE+k] = $urandom;
        display_sel = 1'b1;
        run_and_check("after_reset", -1);

        // start while busy is ignored
        run_and_check("start_busy", 3);

        // start from DONE re-reads new contents
        for (int k = 0; k <= N; k++) mem[BASE+k] = $urandom;
        run_and_check("restart_done", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logit_result_reader.md
# logit_result_reader

Reads the classifier results the inference datapath writes into the output result RAM: N_NEURONS signed Q16.16 logits plus an optional total-cycle count. It computes the argmax class and drives the board LEDs and six 7-segment displays. The block sits after the fully-connected stage on the RAM's second port and runs once per `start_i` pulse. The datapath's write sequence ends with the last write to that RAM.

## Interface
- DATA_WIDTH, 32, logit/RAM word width (signed two's complement)
- ADDR_WIDTH, 16, result RAM address width
- N_NEURONS, 10, number of logits to read; legal range 2..10
- LOGIT_BASE_ADDR, 1, address of logit 0; logit k is at LOGIT_BASE_ADDR+k; cycle count is at LOGIT_BASE_ADDR+N_NEURONS
- RAM_READ_LATENCY, 2, clocks from an address presented to the matching `ram_q_i`; legal range 1..4

Ports:
- system_clock  in  1  clock
- global_reset  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle pulse: result RAM contents are final
- ram_q_i  in  DATA_WIDTH  result RAM read data
- ram_rdaddress_o  out  ADDR_WIDTH  result RAM read address
- display_sel_i  in  1  0 = class only, 1 = class + cycle count
- busy_o  out  1  read sequence in progress
- done_o  out  1  results valid; held until the next accepted start
- class_o  out  4  argmax index
- max_logit_o  out  DATA_WIDTH  winning logit value
- total_cycles_o  out  DATA_WIDTH  cycle-count word
- leds_o  out  10  one-hot class, valid when done_o = 1
- hex0_o..hex5_o  out  7 each  active-low segments {g,f,e,d,c,b,a}

## Operation
- **Reset values:**
  - FSM in IDLE.
  - `busy_o`=0, `done_o`=0, `class_o`=0.
  - `max_logit_o`=0, `total_cycles_o`=0, `leds_o`=0.
  - `ram_rdaddress_o`=LOGIT_BASE_ADDR.
  - All hex outputs = 7'h7F (blank).
- **FSM states:**
  - IDLE: sample `start_i`.
  - READ: issue one address per cycle.
  - DRAIN: wait out the read latency.
  - DONE: hold results.
- **Transitions:**
  - IDLE or DONE, with `start_i` → READ. On entry, clear `done_o` and set `ram_rdaddress_o`=LOGIT_BASE_ADDR.
  - READ advances the address each cycle until N_WORDS addresses have been issued, then → DRAIN.
  - N_WORDS = N_NEURONS+1 with the cycle-count macro defined, N_NEURONS without it.
  - DRAIN → DONE once the last returned word is consumed.
  - `start_i` is ignored in READ and DRAIN.
- **Return tracking:** a RAM_READ_LATENCY-deep shift register of {valid, word index} tags each returned `ram_q_i`.
- **Argmax:**
  - Word 0 initializes the max and sets class to 0.
  - For word k<N_NEURONS, the max and class update only on a signed strictly-greater compare, so a tie keeps the lower index.
  - Word N_NEURONS, when enabled, loads `total_cycles_o`.
- **On entering DONE:**
  - `leds_o` = 1<<class.
  - `hex0_o` = class digit.
  - `hex1_o`..`hex5_o` = `total_cycles_o`[3:0]..[19:16] when `display_sel_i`=1, otherwise blank.
- `display_sel_i` is combinational into the hex mux while in DONE.

## Timing
- `start_i` is sampled at edge 0.
- Addresses are presented on edges 1..N_WORDS.
- The last data is consumed at edge N_WORDS+RAM_READ_LATENCY.
- `done_o` rises at edge N_WORDS+RAM_READ_LATENCY+1. With defaults and the macro: edge 14.
- `busy_o` is high from edge 1 until `done_o` rises; `busy_o` and `done_o` are never both high.
- Hex and LED outputs are blank/0 while busy.
- A reset mid-sequence returns the block to IDLE with all reset values; no partial result is retained.
- A `start_i` coincident with reset is ignored.

## Configuration
- **LOGIT_READER_CYCLES_EN defined:**
  - Reads the extra word at LOGIT_BASE_ADDR+N_NEURONS into `total_cycles_o`.
  - `display_sel_i` is honoured.
- **Not defined:**
  - N_WORDS = N_NEURONS.
  - `total_cycles_o` is held at 0.
  - `hex1_o`..`hex5_o` are always blank.

## Structure
- **Shared package `cnn_pkg`:**
  - FSM state enum.
  - `HEX_BLANK` = 7'h7F constant.
  - Q16.16 fractional-width constant.
- **Sub-module `seven_seg_decoder`:**
  - 4-bit in, 7-bit active-low out, digits 0–F.
  - Six instances.

## Test plan
- **Winner at index 1:** logits {0x654, 0x2BD9, 0xFFFFFAA6, 0xFFFFEFBA, 0xFFFFEDCB, 0xFFFFF75A, 0xFFFFF8F2, 0x8C6, 0xF7, 0x1DA} → `class_o`=1, `max_logit_o`=0x2BD9, `leds_o`=10'b0000000010, `done_o` at edge 14.
- **All negative:** logits all negative, with the largest 0xFFFFFFF0 at index 9 → `class_o`=9, `hex0_o` shows "9".
- **Tie:** indices 3 and 6 both 0x10000, others 0 → `class_o`=3.
- **Cycle display:** cycle word 0x00012345 with `display_sel_i`=1 → `hex5_o`..`hex1_o` show 1,2,3,4,5. With `display_sel_i`=0 the same five displays are blank. Without LOGIT_READER_CYCLES_EN, `total_cycles_o`=0 and `done_o` rises at edge 13.
- **Reset mid-read:** assert `global_reset` at edge 5 → all reset values. A new `start_i` then produces correct results with the same latency.
- **Start while busy:** `start_i` at edge 3 during READ is ignored and the result is unchanged. `start_i` while in DONE clears `done_o` on the next edge and re-reads.
